// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a small FIFO and sequences each one through the ALU
// (issue, capture, respond). Optional divide-by-zero trap: define ALU_DIV0_TRAP_EN.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_a,
  input  logic [3:0]  cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [3:0]  alu_c,
  output logic        alu_oe,
  input  logic [15:0] alu_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_op,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  op_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = AW'(DEPTH) == '0 ? {1'b1, {AW{1'b0}}} : (AW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  state_t        state_q, state_d;

  logic [3:0]  alu_a_q, alu_b_q, alu_c_q;
  logic [15:0] rsp_data_q;
  logic [3:0]  rsp_op_q;
  logic        rsp_err_q;
  logic [7:0]  op_count_q;

  logic push, pop, load, cap, trap, done, div0_trap;
  cmd_t head;

  assign head      = mem_q[rd_ptr_q];
  assign cmd_ready = (cnt_q != FULL);
  assign push      = cmd_valid & cmd_ready;

`ifdef ALU_DIV0_TRAP_EN
  assign div0_trap = (head.op == 4'b0101) && (head.b == 4'd0);
`else
  assign div0_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_t'{a: cmd_a, b: cmd_b, op: cmd_op};
  end

  // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    cap     = 1'b0;
    trap    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop = 1'b1;
        if (div0_trap) begin
          trap    = 1'b1;
          state_d = RESP;
        end else begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        cap     = 1'b1;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Trapped commands never reach the ALU, so the operand registers keep the last issued values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_c_q    <= '0;
      rsp_data_q <= '0;
      rsp_op_q   <= '0;
      rsp_err_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      if (load) begin
        alu_a_q <= head.a;
        alu_b_q <= head.b;
        alu_c_q <= head.op;
      end
      if (cap) begin
        rsp_data_q <= alu_y;
        rsp_op_q   <= alu_c_q;
        rsp_err_q  <= 1'b0;
      end else if (trap) begin
        rsp_data_q <= 16'hFFFF;
        rsp_op_q   <= head.op;
        rsp_err_q  <= 1'b1;
      end
      if (done) op_count_q <= op_count_q + 8'd1;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c     = alu_c_q;
  assign alu_oe    = (state_q == ISSUE) || (state_q == CAPTURE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != IDLE) || (cnt_q != '0);

endmodule
